// File: rtl/dram_responder.sv
// Single-rank SDRAM-style responder: decodes strobe edges into activate/precharge/CAS
// and returns reads through a CL-deep pipeline. Define DRAM_TIMING_CHECK_EN to enforce tRCD/tRP.
//
// state      | meaning
// ST_CLOSED  | no row open; CAS is rejected and flags err
// ST_OPEN    | row latched by activate; CAS reads/writes {row, col}
module dram_responder #(
  parameter int MEM_AW = 16,
  parameter int CL     = 5,
  parameter int TRCD   = 3,
  parameter int TRP    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        err
);

  typedef enum logic {ST_CLOSED, ST_OPEN} st_t;

  localparam int WORDS = 1 << MEM_AW;

  st_t              st_q, st_d;
  logic             ras_q, ras_d;
  logic             cas_q, cas_d;
  logic [10:0]      row_q, row_d;
  logic [CL-1:0]    vpipe_q, vpipe_d;
  logic [31:0]      dpipe_q [CL];
  logic [31:0]      dpipe_d [CL];
  logic             err_q, err_d;

  logic [31:0]      mem [WORDS];

  logic             ras_fall, ras_rise, cas_fall;
  logic             act_ok, cas_ok, rd_fire, wr_fire;
  logic [MEM_AW-1:0] idx;
  logic [31:0]      rd_word;

`ifdef DRAM_TIMING_CHECK_EN
  localparam logic [7:0] TRCD_SAT = 8'(TRCD);
  localparam logic [7:0] TRP_SAT  = 8'(TRP);
  logic [7:0] rcd_q, rcd_d;
  logic [7:0] rp_q, rp_d;
  logic       act_early, cas_early;
`endif

  always_comb begin
    ras_d    = DRAM_RASn;
    cas_d    = DRAM_CASn;
    ras_fall = !DRAM_CSn && !DRAM_RASn && ras_q;
    ras_rise = !DRAM_CSn && DRAM_RASn && !ras_q;
    cas_fall = !DRAM_CSn && !DRAM_CASn && cas_q;

`ifdef DRAM_TIMING_CHECK_EN
    // counters hold (cycles since event - 1); +1 gives the spacing of a command this cycle
    act_early = ras_fall && (rp_q + 8'd1 < TRP_SAT);
    act_ok    = ras_fall && !act_early;
    cas_early = act_ok ? (TRCD_SAT != 8'd0) : (rcd_q + 8'd1 < TRCD_SAT);
    rcd_d     = act_ok ? 8'd0 : ((rcd_q < TRCD_SAT) ? rcd_q + 8'd1 : rcd_q);
    rp_d      = ras_rise ? 8'd0 : ((rp_q < TRP_SAT) ? rp_q + 8'd1 : rp_q);
`else
    act_ok    = ras_fall;
`endif

    // RAS event resolves first so a same-cycle CAS sees the resulting state
    st_d  = st_q;
    row_d = row_q;
    if (act_ok) begin
      st_d  = ST_OPEN;
      row_d = DRAM_A;
    end else if (ras_rise) begin
      st_d  = ST_CLOSED;
    end

    idx     = MEM_AW'({row_d, DRAM_A[9:0]});
    rd_word = mem[idx];

    cas_ok = cas_fall && (st_d == ST_OPEN);
    err_d  = err_q || (cas_fall && (st_d != ST_OPEN));
`ifdef DRAM_TIMING_CHECK_EN
    err_d  = err_d || act_early || (cas_ok && cas_early);
    cas_ok = cas_ok && !cas_early;
`endif
    rd_fire = cas_ok && (DRAM_WEn == 4'hF);
    wr_fire = cas_ok && (DRAM_WEn != 4'hF);

    vpipe_d    = (vpipe_q << 1) | CL'(rd_fire);
    dpipe_d[0] = rd_word;
    for (int i = 1; i < CL; i++) dpipe_d[i] = dpipe_q[i-1];
    // last data stage doubles as the output register and only loads on a valid beat
    if (!vpipe_d[CL-1]) dpipe_d[CL-1] = dpipe_q[CL-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_CLOSED;
      ras_q   <= 1'b1;
      cas_q   <= 1'b1;
      row_q   <= '0;
      vpipe_q <= '0;
      for (int i = 0; i < CL; i++) dpipe_q[i] <= '0;
      err_q   <= 1'b0;
`ifdef DRAM_TIMING_CHECK_EN
      rcd_q   <= TRCD_SAT;
      rp_q    <= TRP_SAT;
`endif
    end else begin
      st_q    <= st_d;
      ras_q   <= ras_d;
      cas_q   <= cas_d;
      row_q   <= row_d;
      vpipe_q <= vpipe_d;
      for (int i = 0; i < CL; i++) dpipe_q[i] <= dpipe_d[i];
      err_q   <= err_d;
`ifdef DRAM_TIMING_CHECK_EN
      rcd_q   <= rcd_d;
      rp_q    <= rp_d;
`endif
    end
  end

  // storage survives reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (!DRAM_WEn[b]) mem[idx][8*b +: 8] <= DRAM_D[8*b +: 8];
      end
    end
  end

  assign DRAM_Q     = dpipe_q[CL-1];
  assign DRAM_valid = vpipe_q[CL-1];
  assign err        = err_q;

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 16: log2 of the number of 32-bit words stored.
REQ-002 SHALL have parameter CL, default 5, range 1..8: CAS-to-data latency in clk cycles.
REQ-003 SHALL have parameter TRCD, default 3: minimum number of cycles from row activate to CAS.
REQ-004 SHALL have parameter TRP, default 3: minimum number of cycles from precharge to the next activate.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; every state change happens on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port DRAM_CSn, input, 1 bit: chip select, active-low.
REQ-008 SHALL have port DRAM_RASn, input, 1 bit: row strobe, active-low.
REQ-009 SHALL have port DRAM_CASn, input, 1 bit: column strobe, active-low.
REQ-010 SHALL have port DRAM_WEn, input, 4 bits: per-byte write enables, active-low; bit i gates byte i.
REQ-011 SHALL have port DRAM_A, input, 11 bits: row address at activate, column address in A[9:0] at CAS.
REQ-012 SHALL have port DRAM_D, input, 32 bits: write data.
REQ-013 SHALL have port DRAM_Q, output, 32 bits: read data.
REQ-014 SHALL have port DRAM_valid, output, 1 bit: DRAM_Q holds read data this cycle.
REQ-015 SHALL have port err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-016 SHALL register the previous RASn and CASn values (ras_q, cas_q); both reset to 1.
REQ-017 SHALL treat a command as issued only when DRAM_CSn=0; with DRAM_CSn=1, strobe edges are ignored while the read pipeline keeps draining.
REQ-018 SHALL perform ACTIVATE on an RASn falling edge (RASn=0, ras_q=1): latch row=A, enter state OPEN, clear the RCD counter.
REQ-019 SHALL perform PRECHARGE on an RASn rising edge: enter state CLOSED, clear the RP counter.
REQ-020 SHALL perform a CAS command on a CASn falling edge while in state OPEN; word index = low MEM_AW bits of {row, A[9:0]}.
REQ-021 SHALL treat a CAS with WEn=4'hF as a read: capture the array word in the CAS cycle, then present it on DRAM_Q with DRAM_valid=1 for exactly one cycle, CL cycles later.
REQ-022 SHALL treat a CAS with WEn!=4'hF as a write: in the CAS cycle, write only the bytes of DRAM_D whose WEn bit is 0; no DRAM_valid pulse.
REQ-023 SHALL keep DRAM_Q at its last value when DRAM_valid=0.
REQ-024 SHALL implement the read latency as a CL-deep valid/data shift pipeline, so reads on successive CAS edges return in issue order with no loss.
REQ-025 SHALL make a read CAS in the cycle after a write to the same word return the newly written data.
REQ-026 SHALL ignore a CAS while CLOSED and set err.
REQ-027 SHALL, on simultaneous RASn and CASn edges in one cycle, process the RAS event first and evaluate CAS against the resulting state.
REQ-028 SHALL saturate the RCD and RP counters at their thresholds.

Reset
REQ-029 SHALL, on rst=1 (asynchronous), set state CLOSED, clear the read pipeline, and drive DRAM_valid=0, DRAM_Q=0, err=0.
REQ-030 SHALL preset the RCD and RP counters saturated on reset.
REQ-031 SHALL NOT reset the storage array; its contents persist across reset.
REQ-032 SHALL discard any read in flight when reset is asserted; no DRAM_valid pulse follows.

Configuration
REQ-033 SHALL, with macro DRAM_TIMING_CHECK_EN defined, ignore a CAS occurring fewer than TRCD cycles after ACTIVATE, and an ACTIVATE occurring fewer than TRP cycles after PRECHARGE; each such violation sets err.
REQ-034 SHALL, with DRAM_TIMING_CHECK_EN undefined, omit the counters, accept commands regardless of spacing, and set err only per REQ-026.

Verification
REQ-035 SHALL test basic write/read: ACT row 0x005, wait 3, CAS write col 0x010 with D=0xDEADBEEF and WEn=0 -> a later CAS read of col 0x010 gives DRAM_valid 5 cycles after CAS with Q=0xDEADBEEF.
REQ-036 SHALL test byte writes: over the same word, write WEn=4'b1010 with D=0x11223344 -> read returns 0xDE22BE44.
REQ-037 SHALL test back-to-back reads: three CAS reads on successive falling edges (cols 0, 1, 2) -> three valid pulses in the same order with matching data.
REQ-038 SHALL test CAS while closed: PRECHARGE, then CAS read -> no DRAM_valid pulse and err=1.
REQ-039 SHALL test reset mid-read: assert rst 2 cycles after a read CAS -> DRAM_valid stays 0; stored data remains readable after reset.
REQ-040 SHALL, with DRAM_TIMING_CHECK_EN defined, test early CAS: CAS 1 cycle after ACT -> command ignored and err=1.
